// File: rtl/ysyx_23060208_isram_axi.sv
// ----------------------------------------------------------------------------
// ysyx_23060208_isram_axi
// Read-only AXI4 instruction SRAM slave that feeds the IFU. The memory is a
// word array. The first response beat follows the address handshake after a
// fixed, programmable number of cycles.
// Request-level and per-beat address errors are signalled through rresp.
//
// Ports
//   clock, reset      single clock; reset is synchronous and active-high
//   isram_ar*         read address channel (valid/ready, addr, len, id, size, burst)
//   isram_r*          read data channel (valid/ready, 64-bit data, resp, last, id)
//                     rdata[31:0]  = word at the beat address
//                     rdata[63:32] = word at the beat address + 4 (0 past the end)
// ----------------------------------------------------------------------------
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | arready high; an AR handshake captures the request
// DELAY | latency down-counter running; AR channel blocked
// RESP  | beat presented on R; advances on rvalid && rready
// ----------------------------------------------------------------------------
module ysyx_23060208_isram_axi #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] ADDR_BASE  = 32'h8000_0000,
   parameter int                    MEM_WORDS  = 65536,
   parameter int                    LATENCY    = 1,
   parameter string                 INIT_FILE  = ""
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    isram_arvalid,
   output logic                    isram_arready,
   input  logic [DATA_WIDTH-1:0]   isram_araddr,
   input  logic [7:0]              isram_arlen,
   input  logic [3:0]              isram_arid,
   input  logic [2:0]              isram_arsize,
   input  logic [1:0]              isram_arburst,
   output logic                    isram_rvalid,
   input  logic                    isram_rready,
   output logic [2*DATA_WIDTH-1:0] isram_rdata,
   output logic [1:0]              isram_rresp,
   output logic                    isram_rlast,
   output logic [3:0]              isram_rid
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   // Byte size of the array, one bit wider than an address so that a
   // memory reaching the top of the address space still compares correctly.
   localparam logic [DATA_WIDTH:0] MEM_BYTES = (DATA_WIDTH+1)'(MEM_WORDS) << 2;
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   state_t state_q, state_d;

   // Captured request
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic [3:0]            id_q, id_d;
   logic [1:0]            err_q, err_d;
   logic                  fixed_q, fixed_d;
   logic [7:0]            beat_q, beat_d;
   logic [3:0]            dly_q, dly_d;

   // Registered R channel
   logic                    rvalid_q, rvalid_d;
   logic [2*DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;
   logic                    rlast_q, rlast_d;
   logic [3:0]              rid_q, rid_d;

   // Beat load request: when ld is set the R registers are refilled from
   // the lookup of ld_addr in the same cycle.
   logic                  ld;
   logic [DATA_WIDTH-1:0] ld_addr;
   logic [1:0]            ld_err;
   logic [7:0]            ld_beat;
   logic [7:0]            ld_len;
   logic [3:0]            ld_id;

   logic                  ar_hs;
   logic [1:0]            req_err;
   logic [DATA_WIDTH-1:0] next_addr;

   logic [DATA_WIDTH-1:0]   hi_addr, lo_off, hi_off;
   logic                    lo_in, hi_in;
   logic [AW-1:0]           lo_idx, hi_idx;
   logic [1:0]              lk_resp;
   logic [2*DATA_WIDTH-1:0] lk_data;

   assign isram_rvalid = rvalid_q;
   assign isram_rdata  = rdata_q;
   assign isram_rresp  = rresp_q;
   assign isram_rlast  = rlast_q;
   assign isram_rid    = rid_q;

   assign ar_hs = isram_arvalid && isram_arready;

   // Request-level errors take priority over alignment, which takes
   // priority over the per-beat range check done in the lookup.
   always_comb begin
      req_err = RESP_OKAY;
      if ((isram_arsize != 3'b010) || (isram_arburst == 2'b10) || (isram_arlen > 8'd15))
         req_err = RESP_SLVERR;
      else if (isram_araddr[1:0] != 2'b00)
         req_err = RESP_DECERR;
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ar_hs) state_d = (LATENCY > 0) ? S_DELAY : S_RESP;
         end
         S_DELAY: begin
            if (dly_q == 4'd0) state_d = S_RESP;
         end
         S_RESP: begin
            if (isram_rready && rlast_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath control
   // ------------------------------------------------------------------
   always_comb begin
      isram_arready = (state_q == S_IDLE) && !reset;

      addr_d    = addr_q;
      len_d     = len_q;
      id_d      = id_q;
      err_d     = err_q;
      fixed_d   = fixed_q;
      beat_d    = beat_q;
      dly_d     = dly_q;
      next_addr = fixed_q ? addr_q : addr_q + DATA_WIDTH'(4);

      ld      = 1'b0;
      ld_addr = addr_q;
      ld_err  = err_q;
      ld_beat = beat_q;
      ld_len  = len_q;
      ld_id   = id_q;

      case (state_q)
         S_IDLE: begin
            if (ar_hs) begin
               addr_d  = isram_araddr;
               len_d   = isram_arlen;
               id_d    = isram_arid;
               err_d   = req_err;
               fixed_d = (isram_arburst == 2'b00);
               beat_d  = 8'd0;
               dly_d   = LAT_M1;
               // Zero latency: first beat goes straight from the AR inputs.
               if (LATENCY == 0) begin
                  ld      = 1'b1;
                  ld_addr = isram_araddr;
                  ld_err  = req_err;
                  ld_beat = 8'd0;
                  ld_len  = isram_arlen;
                  ld_id   = isram_arid;
               end
            end
         end
         S_DELAY: begin
            if (dly_q == 4'd0) ld = 1'b1;
            else               dly_d = dly_q - 4'd1;
         end
         S_RESP: begin
            if (isram_rready && !rlast_q) begin
               addr_d  = next_addr;
               beat_d  = beat_q + 8'd1;
               ld      = 1'b1;
               ld_addr = next_addr;
               ld_beat = beat_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   // Memory lookup for the beat being loaded. Offsets are taken modulo
   // 2^DATA_WIDTH, so addresses below the base wrap to large offsets and
   // fall out of range.
   always_comb begin
      hi_addr = ld_addr + DATA_WIDTH'(4);
      lo_off  = ld_addr - ADDR_BASE;
      hi_off  = hi_addr - ADDR_BASE;
      lo_in   = {1'b0, lo_off} < MEM_BYTES;
      hi_in   = {1'b0, hi_off} < MEM_BYTES;
      lo_idx  = AW'(lo_off >> 2);
      hi_idx  = AW'(hi_off >> 2);

      if (ld_err != RESP_OKAY) lk_resp = ld_err;
      else if (!lo_in)         lk_resp = RESP_DECERR;
      else                     lk_resp = RESP_OKAY;

      lk_data = '0;
      if (lk_resp == RESP_OKAY) begin
         lk_data[DATA_WIDTH-1:0] = mem[lo_idx];
         if (hi_in) lk_data[2*DATA_WIDTH-1:DATA_WIDTH] = mem[hi_idx];
      end
   end

   // R channel next values; everything holds unless a beat is loaded or
   // the final beat is accepted.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      rlast_d  = rlast_q;
      rid_d    = rid_q;
      if (ld) begin
         rvalid_d = 1'b1;
         rdata_d  = lk_data;
         rresp_d  = lk_resp;
         rlast_d  = (ld_beat == ld_len);
         rid_d    = ld_id;
      end else if ((state_q == S_RESP) && isram_rready && rlast_q) begin
         rvalid_d = 1'b0;
         rlast_d  = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q   <= '0;
         len_q    <= '0;
         id_q     <= '0;
         err_q    <= RESP_OKAY;
         fixed_q  <= 1'b0;
         beat_q   <= '0;
         dly_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         rlast_q  <= 1'b0;
         rid_q    <= '0;
      end else begin
         addr_q   <= addr_d;
         len_q    <= len_d;
         id_q     <= id_d;
         err_q    <= err_d;
         fixed_q  <= fixed_d;
         beat_q   <= beat_d;
         dly_q    <= dly_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         rlast_q  <= rlast_d;
         rid_q    <= rid_d;
      end
   end

endmodule

// File: tb/tb_ysyx_23060208_isram_axi.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060208_isram_axi
// Directed bench for the instruction SRAM slave. Two instances share the AR
// payload, rready and reset: dut_l1 uses LATENCY=1, dut_l0 uses LATENCY=0.
// Both are given a 64-word memory whose contents come from word() below.
// ----------------------------------------------------------------------------
module tb_ysyx_23060208_isram_axi;

    logic        clock = 1'b0;
    logic        reset;
    logic        arvalid0, arvalid1;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [3:0]  arid;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;

    logic        arready0, arready1;
    logic        rvalid0, rvalid1;
    logic [63:0] rdata0, rdata1;
    logic [1:0]  rresp0, rresp1;
    logic        rlast0, rlast1;
    logic [3:0]  rid0, rid1;

    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    ysyx_23060208_isram_axi #(
        .MEM_WORDS (64),
        .LATENCY   (1)
    ) dut_l1 (
        .clock         (clock),
        .reset         (reset),
        .isram_arvalid (arvalid1),
        .isram_arready (arready1),
        .isram_araddr  (araddr),
        .isram_arlen   (arlen),
        .isram_arid    (arid),
        .isram_arsize  (arsize),
        .isram_arburst (arburst),
        .isram_rvalid  (rvalid1),
        .isram_rready  (rready),
        .isram_rdata   (rdata1),
        .isram_rresp   (rresp1),
        .isram_rlast   (rlast1),
        .isram_rid     (rid1)
    );

    ysyx_23060208_isram_axi #(
        .MEM_WORDS (64),
        .LATENCY   (0)
    ) dut_l0 (
        .clock         (clock),
        .reset         (reset),
        .isram_arvalid (arvalid0),
        .isram_arready (arready0),
        .isram_araddr  (araddr),
        .isram_arlen   (arlen),
        .isram_arid    (arid),
        .isram_arsize  (arsize),
        .isram_arburst (arburst),
        .isram_rvalid  (rvalid0),
        .isram_rready  (rready),
        .isram_rdata   (rdata0),
        .isram_rresp   (rresp0),
        .isram_rlast   (rlast0),
        .isram_rid     (rid0)
    );

    function automatic logic [31:0] word(input int k);
        if (k == 0) return 32'h0000_0413;
        if (k == 1) return 32'h0010_0093;
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one AR request to the selected instance for one cycle.
    // Returns in the cycle after the handshake edge.
    task automatic ar_send(input bit lat0, input logic [31:0] a, input logic [7:0] l,
                           input logic [3:0] id, input logic [2:0] sz, input logic [1:0] bu);
        araddr  = a;
        arlen   = l;
        arid    = id;
        arsize  = sz;
        arburst = bu;
        if (lat0) arvalid0 = 1'b1;
        else      arvalid1 = 1'b1;
        check("arready_idle", lat0 ? arready0 : arready1, 1);
        step();
        arvalid0 = 1'b0;
        arvalid1 = 1'b0;
    endtask

    task automatic wait_rv(input bit lat0, input int max);
        int n = 0;
        while (((lat0 ? rvalid0 : rvalid1) !== 1'b1) && (n < max)) begin
            step();
            n++;
        end
        check("rvalid_wait", lat0 ? rvalid0 : rvalid1, 1);
    endtask

    task automatic beat_check(input bit lat0, input string tag, input logic [63:0] d,
                              input logic [1:0] r, input logic l, input logic [3:0] id);
        check({tag, "_rvalid"}, lat0 ? rvalid0 : rvalid1, 1);
        check({tag, "_rdata"},  lat0 ? rdata0  : rdata1,  d);
        check({tag, "_rresp"},  lat0 ? rresp0  : rresp1,  r);
        check({tag, "_rlast"},  lat0 ? rlast0  : rlast1,  l);
        check({tag, "_rid"},    lat0 ? rid0    : rid1,    id);
    endtask

    initial begin
        reset    = 1'b1;
        arvalid0 = 1'b0;
        arvalid1 = 1'b0;
        araddr   = '0;
        arlen    = '0;
        arid     = '0;
        arsize   = 3'b010;
        arburst  = 2'b01;
        rready   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dut_l1.mem[6'(i)] = word(i);
            dut_l0.mem[6'(i)] = word(i);
        end

        // 1: reset behaviour
        repeat (3) begin
            step();
            check("rst_arready", arready1, 0);
            check("rst_rvalid", rvalid1, 0);
        end
        check("rst_rdata", rdata1, 0);
        check("rst_arready_l0", arready0, 0);
        reset = 1'b0;
        #1;
        check("post_rst_arready", arready1, 1);

        // 2: single beat, LATENCY=1 -> rvalid at T+2
        rready = 1'b1;
        ar_send(0, 32'h8000_0000, 8'd0, 4'd3, 3'b010, 2'b01);
        check("t2_gap_rvalid", rvalid1, 0);
        step();
        beat_check(0, "t2", {32'h0010_0093, 32'h0000_0413}, 2'b00, 1'b1, 4'd3);
        check("t2_arready_busy", arready1, 0);
        step();
        check("t2_arready_back", arready1, 1);
        check("t2_rvalid_done", rvalid1, 0);

        // 3: INCR len=3 from word 2 with rready stalls
        rready = 1'b0;
        ar_send(0, 32'h8000_0008, 8'd3, 4'd7, 3'b010, 2'b01);
        wait_rv(0, 8);
        for (int b = 0; b < 4; b++) begin
            beat_check(0, "t3", {word(b + 3), word(b + 2)}, 2'b00, b == 3, 4'd7);
            rready = 1'b0;
            step();
            beat_check(0, "t3_hold", {word(b + 3), word(b + 2)}, 2'b00, b == 3, 4'd7);
            rready = 1'b1;
            step();
        end
        check("t3_done", rvalid1, 0);

        // 4: below range and misaligned
        ar_send(0, 32'h7FFF_FFFC, 8'd0, 4'd1, 3'b010, 2'b01);
        wait_rv(0, 8);
        beat_check(0, "t4_low", 64'h0, 2'b11, 1'b1, 4'd1);
        step();
        ar_send(0, 32'h8000_0002, 8'd0, 4'd2, 3'b010, 2'b01);
        wait_rv(0, 8);
        beat_check(0, "t4_mis", 64'h0, 2'b11, 1'b1, 4'd2);
        step();

        // 5: unsupported size / burst
        ar_send(0, 32'h8000_0000, 8'd1, 4'd4, 3'b011, 2'b01);
        wait_rv(0, 8);
        beat_check(0, "t5_sz_b0", 64'h0, 2'b10, 1'b0, 4'd4);
        step();
        beat_check(0, "t5_sz_b1", 64'h0, 2'b10, 1'b1, 4'd4);
        step();
        check("t5_done", rvalid1, 0);
        ar_send(0, 32'h8000_0000, 8'd0, 4'd6, 3'b010, 2'b10);
        wait_rv(0, 8);
        beat_check(0, "t5_wrap", 64'h0, 2'b10, 1'b1, 4'd6);
        step();

        // Top of memory: upper half past the end reads 0 with OKAY
        ar_send(0, 32'h8000_00FC, 8'd0, 4'd8, 3'b010, 2'b01);
        wait_rv(0, 8);
        beat_check(0, "top", {32'h0, word(63)}, 2'b00, 1'b1, 4'd8);
        step();
        ar_send(0, 32'h8000_0100, 8'd0, 4'd9, 3'b010, 2'b01);
        wait_rv(0, 8);
        beat_check(0, "past_end", 64'h0, 2'b11, 1'b1, 4'd9);
        step();

        // FIXED burst repeats the same address
        ar_send(0, 32'h8000_0010, 8'd1, 4'd10, 3'b010, 2'b00);
        wait_rv(0, 8);
        beat_check(0, "fix_b0", {word(5), word(4)}, 2'b00, 1'b0, 4'd10);
        step();
        beat_check(0, "fix_b1", {word(5), word(4)}, 2'b00, 1'b1, 4'd10);
        step();

        // 6: reset mid-burst on the LATENCY=0 instance
        ar_send(1, 32'h8000_0000, 8'd3, 4'd2, 3'b010, 2'b01);
        beat_check(1, "t6_b0", {word(1), word(0)}, 2'b00, 1'b0, 4'd2);
        step();
        beat_check(1, "t6_b1", {word(2), word(1)}, 2'b00, 1'b0, 4'd2);
        step();
        beat_check(1, "t6_b2", {word(3), word(2)}, 2'b00, 1'b0, 4'd2);
        reset = 1'b1;
        step();
        check("t6_rst_rvalid", rvalid0, 0);
        reset = 1'b0;
        #1;
        check("t6_arready", arready0, 1);
        ar_send(1, 32'h8000_0004, 8'd0, 4'd5, 3'b010, 2'b01);
        beat_check(1, "t6_new", {word(2), word(1)}, 2'b00, 1'b1, 4'd5);
        step();
        check("t6_done", rvalid0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
